// File: rtl/pipe_stage_regs.sv
// Elastic inter-stage register: STAGES valid/ready slots with stall, flush,
// bubble collapsing and masking of control bits whenever a slot is empty.
module pipe_stage_regs #(
  parameter int unsigned                PAYLOAD_WIDTH = 107,
  parameter int unsigned                STAGES        = 1,
  parameter logic [PAYLOAD_WIDTH-1:0]   CLEAR_MASK    = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PAYLOAD_WIDTH-1:0]         in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PAYLOAD_WIDTH-1:0]         out_data,
  output logic [$clog2(STAGES+1)-1:0]      occupancy
);

  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  logic [PAYLOAD_WIDTH-1:0] slot_q [STAGES];
  logic [PAYLOAD_WIDTH-1:0] slot_d [STAGES];
  logic [STAGES-1:0]        v_q;
  logic [STAGES-1:0]        v_d;
  logic [STAGES:0]          rdy;
  logic [OCC_W-1:0]         occ;

  // A slot can take new contents when it is empty or its contents move on;
  // evaluated from the output side so empty slots absorb entries behind them.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int unsigned k = 0; k < STAGES; k++) begin
      rdy[STAGES-1-k] = !v_q[STAGES-1-k] || rdy[STAGES-k];
    end
  end

  always_comb begin
    v_d    = v_q;
    slot_d = slot_q;
    if (flush) begin
      v_d = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        slot_d[k] = slot_q[k] & ~CLEAR_MASK;
      end
    end else begin
      if (rdy[0]) begin
        slot_d[0] = in_data;
        v_d[0]    = in_valid;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          slot_d[k] = slot_q[k-1];
          v_d[k]    = v_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      v_q    <= v_d;
      slot_q <= slot_d;
    end
  end

  always_comb begin
    occ = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      occ = occ + OCC_W'(v_q[k]);
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign out_data  = v_q[STAGES-1] ? slot_q[STAGES-1]
                                   : (slot_q[STAGES-1] & ~CLEAR_MASK);
  assign occupancy = occ;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Bench for pipe_stage_regs: three instances (STAGES=1,2,3) checked every cycle
// against a position-based entry model, plus directed literal scenarios.
module tb_pipe_stage_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv   [3];
  logic       fl   [3];
  logic       ordy [3];
  logic [7:0] id   [3];

  logic       ir0, ir1, ir2, ov0, ov1, ov2;
  logic [7:0] od0, od1, od2;
  logic [0:0] occ0;
  logic [1:0] occ1, occ2;

  pipe_stage_regs #(.PAYLOAD_WIDTH(8), .STAGES(1), .CLEAR_MASK(8'h80)) dut0 (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir0),
    .in_data(id[0]), .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0),
    .occupancy(occ0));
  pipe_stage_regs #(.PAYLOAD_WIDTH(8), .STAGES(2), .CLEAR_MASK(8'h03)) dut1 (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir1),
    .in_data(id[1]), .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1),
    .occupancy(occ1));
  pipe_stage_regs #(.PAYLOAD_WIDTH(8), .STAGES(3), .CLEAR_MASK(8'hC1)) dut2 (
    .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir2),
    .in_data(id[2]), .out_valid(ov2), .out_ready(ordy[2]), .out_data(od2),
    .occupancy(occ2));

  int         SS [3] = '{1, 2, 3};
  logic [7:0] MK [3] = '{8'h80, 8'h03, 8'hC1};

  // Model: entries oldest-first, each with its slot position (0 = input side).
  int         mcnt [3];
  int         mpos [3][4];
  logic [7:0] mdat [3][4];

  logic [7:0] obs1 [$];
  logic [7:0] obs2 [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic get_out(input int k, output logic r, output logic v,
                         output logic [7:0] d, output int o);
    case (k)
      0:       begin r = ir0; v = ov0; d = od0; o = int'(occ0); end
      1:       begin r = ir1; v = ov1; d = od1; o = int'(occ1); end
      default: begin r = ir2; v = ov2; d = od2; o = int'(occ2); end
    endcase
  endtask

  task automatic model_update(input int k);
    logic acc;
    int   lim;
    if (rst) begin
      mcnt[k] = 0;
      return;
    end
    acc = iv[k] && ((mcnt[k] < SS[k]) || ordy[k]);
    if (mcnt[k] > 0 && mpos[k][0] == SS[k] - 1 && ordy[k]) begin
      for (int j = 0; j < mcnt[k] - 1; j++) begin
        mdat[k][j] = mdat[k][j+1];
        mpos[k][j] = mpos[k][j+1];
      end
      mcnt[k]--;
    end
    if (fl[k]) begin
      mcnt[k] = 0;
      return;
    end
    for (int j = 0; j < mcnt[k]; j++) begin
      lim = (j == 0) ? SS[k] : mpos[k][j-1];
      if (mpos[k][j] + 1 < lim) mpos[k][j]++;
    end
    if (acc) begin
      mdat[k][mcnt[k]] = id[k];
      mpos[k][mcnt[k]] = 0;
      mcnt[k]++;
    end
  endtask

  task automatic compare(input int k);
    logic       r, v, ev;
    logic [7:0] d;
    int         o;
    get_out(k, r, v, d, o);
    ev = (mcnt[k] > 0) && (mpos[k][0] == SS[k] - 1);
    chk("occupancy", k, o, mcnt[k]);
    chk("in_ready", k, r, (mcnt[k] < SS[k]) || ordy[k]);
    chk("out_valid", k, v, ev);
    if (ev) chk("out_data", k, d, mdat[k][0]);
    else    chk("masked_bits", k, d & MK[k], 8'h00);
  endtask

  // Inputs are final here; record the transfers the coming edge will complete.
  task automatic step();
    if (!rst) begin
      if (ov1 && ordy[1]) obs1.push_back(od1);
      if (ov2 && ordy[2]) obs2.push_back(od2);
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) compare(k);
  endtask

  initial begin
    int   val;
    logic acc;
    int   pr;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b1; id[k] = 8'hFF; ordy[k] = 1'b1; fl[k] = 1'b0; mcnt[k] = 0;
    end
    step();
    step();
    chk("rst_out_data", 0, od0, 8'h00);
    chk("rst_out_data", 1, od1, 8'h00);
    chk("rst_out_data", 2, od2, 8'h00);
    chk("rst_in_ready", 1, ir1, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    step();

    // STAGES=1 behaves as a plain register.
    iv[0] = 1'b1; id[0] = 8'h7E;
    step();
    iv[0] = 1'b0;
    chk("s1_latency_data", 0, od0, 8'h7E);
    chk("s1_latency_valid", 0, ov0, 1'b1);
    step();

    // STAGES=2 single entry.
    iv[1] = 1'b1; id[1] = 8'hA5;
    step();
    iv[1] = 1'b0;
    step();
    chk("a5_valid", 1, ov1, 1'b1);
    chk("a5_data", 1, od1, 8'hA5);
    step();

    // Streaming through STAGES=3.
    obs2.delete();
    for (int i = 1; i <= 12; i++) begin
      iv[2] = 1'b1; id[2] = 8'(i);
      step();
      if (i == 3) begin
        chk("stream_first", 2, od2, 8'd1);
        chk("stream_occ", 2, occ2, 2'd3);
      end
    end
    iv[2] = 1'b0;
    repeat (4) step();
    chk("stream_count", 2, obs2.size(), 12);
    for (int i = 0; i < obs2.size(); i++) chk("stream_order", 2, obs2[i], 8'(i + 1));

    // Stall and fill.
    obs2.delete();
    ordy[2] = 1'b0;
    val = 10;
    repeat (6) begin
      iv[2] = 1'b1; id[2] = 8'(val);
      acc = ir2;
      step();
      if (acc) val++;
    end
    chk("fill_accepts", 2, val, 13);
    chk("fill_in_ready", 2, ir2, 1'b0);
    chk("fill_head", 2, od2, 8'd10);
    ordy[2] = 1'b1;
    step();
    iv[2] = 1'b0;
    repeat (5) step();
    chk("fill_count", 2, obs2.size(), 4);
    for (int i = 0; i < obs2.size(); i++) chk("fill_order", 2, obs2[i], 8'(10 + i));

    // Bubble collapse.
    ordy[2] = 1'b0;
    iv[2] = 1'b1; id[2] = 8'h55;
    step();
    iv[2] = 1'b0;
    repeat (5) step();
    chk("bubble_occ", 2, occ2, 2'd1);
    chk("bubble_valid", 2, ov2, 1'b1);
    chk("bubble_data", 2, od2, 8'h55);
    chk("bubble_in_ready", 2, ir2, 1'b1);
    ordy[2] = 1'b1;
    repeat (2) step();

    // Flush of a full, stalled pipe.
    obs2.delete();
    ordy[2] = 1'b0;
    for (int v = 20; v <= 22; v++) begin
      iv[2] = 1'b1; id[2] = 8'(v);
      step();
    end
    fl[2] = 1'b1; iv[2] = 1'b1; id[2] = 8'd99;
    step();
    fl[2] = 1'b0; iv[2] = 1'b0;
    chk("flush_occ", 2, occ2, 2'd0);
    chk("flush_valid", 2, ov2, 1'b0);
    chk("flush_mask", 2, od2 & 8'hC1, 8'h00);
    chk("flush_in_ready", 2, ir2, 1'b1);
    ordy[2] = 1'b1;
    repeat (5) step();
    chk("flush_nothing_out", 2, obs2.size(), 0);

    // Reset together with flush clears payload fully.
    ordy[1] = 1'b0;
    iv[1] = 1'b1; id[1] = 8'hFF;
    step();
    step();
    iv[1] = 1'b0;
    rst = 1'b1; fl[1] = 1'b1;
    step();
    rst = 1'b0; fl[1] = 1'b0;
    chk("rstflush_data", 1, od1, 8'h00);
    chk("rstflush_occ", 1, occ1, 2'd0);
    chk("rstflush_valid", 1, ov1, 1'b0);

    // Output transfer completes during flush; entry behind it is killed.
    obs1.delete();
    ordy[1] = 1'b1;
    iv[1] = 1'b1; id[1] = 8'h3C;
    step();
    id[1] = 8'h4D;
    step();
    iv[1] = 1'b0;
    chk("pre_flush_head", 1, od1, 8'h3C);
    fl[1] = 1'b1;
    step();
    fl[1] = 1'b0;
    repeat (3) step();
    chk("flush_xfer_count", 1, obs1.size(), 1);
    chk("flush_xfer_val", 1, (obs1.size() > 0) ? 32'(obs1[0]) : 32'hDEAD, 8'h3C);
    chk("flush_xfer_empty", 1, ov1, 1'b0);

    // Randomized traffic on all instances.
    for (int n = 0; n < 3000; n++) begin
      pr  = (n < 1500) ? 35 : 80;
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 3; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        id[k]   = 8'($urandom);
        ordy[k] = ($urandom_range(0, 99) < pr);
        fl[k]   = ($urandom_range(0, 31) == 0);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Parametrised successor to the fixed inter-stage registers (EX/MEM style) in the pipelined RV32I core.
- Carries an opaque payload (control fields plus data) through STAGES elastic register slots.
- Adds per-slot valid bits, valid/ready backpressure (stall), flush, bubble collapsing, and masking of control bits in bubbles.
- The hazard unit drives stall (out_ready=0) and flush; one instance replaces each hand-written stage register.

Parameters:
- PAYLOAD_WIDTH, 107, total payload bits (control plus data fields concatenated by the instantiating stage)
- STAGES, 1, number of register slots; legal range 1..4
- CLEAR_MASK, {PAYLOAD_WIDTH{1'b0}}, bits forced to 0 on reset/flush and on out_data while out_valid=0 (e.g. RegWrite, MemWrite positions)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous kill of all in-flight entries
- in_valid  in  1  upstream presents a valid payload
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  PAYLOAD_WIDTH  upstream payload
- out_valid  out  1  out_data holds a valid entry
- out_ready  in  1  downstream consumes the entry (0 = stall)
- out_data  out  PAYLOAD_WIDTH  payload of the last slot
- occupancy  out  $clog2(STAGES+1)  count of valid slots

Behaviour:
- One clock; reset is synchronous and active-high: clk and rst, rst sampled on the rising edge of clk.
- State: slot[0..STAGES-1] payload registers and v[0..STAGES-1] valid bits. Slot 0 is the input side; slot STAGES-1 drives the outputs.
- Ready chain (combinational):
  - rdy[STAGES] = out_ready
  - rdy[i] = !v[i] || rdy[i+1]
  - in_ready = rdy[0]
  - No combinational path from in_valid to in_ready.
- Advance rule per edge, for slot i where rdy[i]=1:
  - Slot 0 loads in_data with v[0] <= in_valid.
  - Slot i>0 loads slot[i-1] with v[i] <= v[i-1].
  - Slots with rdy[i]=0 hold payload and valid.
- Transfers occur only when valid and ready are both 1:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- Latency: with out_ready held at 1, an entry accepted at edge N appears on out_data after edge N+STAGES-1 (STAGES=1 gives one-cycle register behaviour, identical to the existing stage registers).
- Bubbles collapse: while stalled, an invalid slot absorbs the entry behind it, so in_ready stays 1 until all STAGES slots are valid.
- out_valid = v[STAGES-1].
- out_data = slot[STAGES-1] & ~CLEAR_MASK when !out_valid; otherwise slot[STAGES-1] unmodified.
- occupancy = popcount(v). Registered-state-derived, no dependence on same-cycle handshakes.
- rst=1:
  - All v <= 0 and all slot payloads <= 0.
  - Outputs after the edge: out_valid=0, out_data=0, occupancy=0, in_ready=1.
- flush=1 (rst=0):
  - All v <= 0; each slot <= slot & ~CLEAR_MASK.
  - in_data presented that cycle is dropped, even if in_ready=1.
  - An output transfer in the same cycle still completes (downstream has sampled it).
- rst and flush together: rst wins.
- Reset or flush mid-stall: all entries are discarded; no entry emerges afterwards.
- Full (occupancy=STAGES) with out_ready=1: in_ready=1 and the pipe shifts. Simultaneous input and output keep occupancy unchanged.
- Empty with out_ready=0: in_ready=1 and entries are accepted until full.
- Any X on the payload is never masked into valid outputs.
- Synthesizable as always_ff plus always_comb only; no latches.

Test Plan:
- Reset/bubble masking (STAGES=2, CLEAR_MASK=0x3 on an 8-bit payload): assert rst with in_data=0xFF, in_valid=1 -> after release, out_valid=0, out_data=0x00, occupancy=0, in_ready=1. Then drive in_valid=1, in_data=0xA5 with out_ready=1 -> out_valid=1 and out_data=0xA5 two edges after acceptance.
- Streaming: STAGES=3, out_ready=1, in_data=1,2,3,... every cycle -> out_data sequence 1,2,3,... starting 3 edges after the first accept, no gaps, occupancy=3 steady.
- Stall/fill: STAGES=3, out_ready=0, in_valid=1 with values 10,11,12,13 -> in_ready drops after 3 accepts, 13 held at input. Raising out_ready -> outputs 10,11,12,13 in order, none lost or duplicated.
- Bubble collapse: STAGES=3, single entry 0x55 then in_valid=0, out_ready=0 for 5 cycles -> 0x55 reaches slot 2, occupancy=1, in_ready=1 throughout.
- Flush mid-operation: STAGES=3, full pipe (entries 20,21,22, out_ready=0), pulse flush with in_valid=1, in_data=99 -> next cycle occupancy=0, out_valid=0, out_data has CLEAR_MASK bits 0. 99 never appears. Flush with rst together behaves as reset.
- Output transfer on flush: out_valid=1, out_ready=1, flush=1 -> scoreboard counts the output entry as delivered; no further outputs until new input.
